// File: rtl/umem_port_arbiter_if.sv
// Handshake and memory-side bundle shared by the fetch/data requesters,
// the unified memory and the port arbiter between them.
interface umem_port_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_valid;
    logic              if_err;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_funct3;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic              dm_err;
    logic [31:0]       dm_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_stall, if_valid, if_err, if_rdata,
        input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        output dm_gnt, dm_valid, dm_err, dm_rdata,
        output mem_addr, mem_read, mem_write, mem_funct3, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_stall, if_valid, if_err, if_rdata,
        output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        input  dm_gnt, dm_valid, dm_err, dm_rdata,
        input  mem_addr, mem_read, mem_write, mem_funct3, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/umem_port_arbiter.sv
// Single-port unified memory arbiter: data first, fetch forced through
// after MAX_FETCH_WAIT denied cycles; responses registered one cycle later.
module umem_port_arbiter #(
    parameter int MAX_FETCH_WAIT = 4,
    parameter int ADDR_W         = 6
) (
    input logic                clk,
    input logic                rst_n,
    umem_port_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_e;

    owner_e      owner_q, owner_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic if_fault;
    logic dm_fault;
    logic dm_f3_bad;
    logic starved;
    logic if_gnt;
    logic dm_gnt;

    always_comb begin
        if_fault = (|bus.if_addr[31:ADDR_W+2]) | (|bus.if_addr[1:0]);
        if (bus.dm_we)
            dm_f3_bad = bus.dm_funct3 > 3'b010;
        else
            dm_f3_bad = bus.dm_funct3 inside {3'b011, 3'b110, 3'b111};
        dm_fault = (|bus.dm_addr[31:ADDR_W+2]) | (|bus.dm_addr[1:0])
                 | dm_f3_bad;
        starved  = wait_cnt_q == WAIT_MAX;
        dm_gnt   = rst_n & bus.dm_req & ~(bus.if_req & starved);
        if_gnt   = rst_n & bus.if_req & ~dm_gnt;
    end

    // Faulted grants are consumed without touching the memory.
    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_funct3 = 3'b000;
        bus.mem_wdata  = '0;
        if (dm_gnt && !dm_fault) begin
            bus.mem_addr   = bus.dm_addr[ADDR_W+1:2];
            bus.mem_read   = ~bus.dm_we;
            bus.mem_write  = bus.dm_we;
            bus.mem_funct3 = bus.dm_funct3;
            bus.mem_wdata  = bus.dm_wdata;
        end else if (if_gnt && !if_fault) begin
            bus.mem_addr   = bus.if_addr[ADDR_W+1:2];
            bus.mem_read   = 1'b1;
            bus.mem_funct3 = 3'b010;
        end
    end

    always_comb begin
        owner_d    = OWN_NONE;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        wait_cnt_d = wait_cnt_q;
        if (!bus.if_req || if_gnt)
            wait_cnt_d = '0;
        else if (!starved)
            wait_cnt_d = wait_cnt_q + 4'd1;
        if (dm_gnt) begin
            owner_d    = OWN_DM;
            err_d      = dm_fault;
            dm_rdata_d = (dm_fault || bus.dm_we) ? '0 : bus.mem_rdata;
        end else if (if_gnt) begin
            owner_d    = OWN_IF;
            err_d      = if_fault;
            if_rdata_d = if_fault ? '0 : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.dm_gnt   = dm_gnt;
    assign bus.if_stall = bus.if_req & ~if_gnt;
    assign bus.if_valid = owner_q == OWN_IF;
    assign bus.dm_valid = owner_q == OWN_DM;
    assign bus.if_err   = bus.if_valid & err_q;
    assign bus.dm_err   = bus.dm_valid & err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_umem_port_arbiter.sv
// Randomized bench for umem_port_arbiter against a transaction-level
// model of arbitration, memory contents and one-cycle responses.
module tb_umem_port_arbiter;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    umem_port_arbiter_if #(.ADDR_W(6)) bus ();

    umem_port_arbiter #(
        .MAX_FETCH_WAIT(MAXW),
        .ADDR_W        (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rd(logic [31:0] w, logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] wr(logic [31:0] w, logic [31:0] d,
                                       logic [2:0] f3);
        case (f3)
            3'b000:  return {w[31:8], d[7:0]};
            3'b001:  return {w[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Memory the DUT talks to: combinational read, store at posedge.
    always_comb begin
        bus.mem_rdata = 32'd0;
        if (bus.mem_read)
            bus.mem_rdata = rd(mem[bus.mem_addr], bus.mem_funct3);
    end

    always @(posedge clk)
        if (bus.mem_write)
            mem[bus.mem_addr] <= wr(mem[bus.mem_addr], bus.mem_wdata,
                                    bus.mem_funct3);

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_addr();
        logic [31:0] a;
        int r;
        a = $urandom_range(0, 63) * 4;
        r = $urandom_range(0, 99);
        if (r < 8)
            a = a | $urandom_range(1, 3);
        else if (r < 14)
            a = a | ($urandom_range(1, 255) << 8);
        return a;
    endfunction

    function automatic bit addr_bad(logic [31:0] a);
        return (a >= 256) || (a % 4 != 0);
    endfunction

    function automatic bit f3_ok(bit we, logic [2:0] f3);
        if (we)
            return f3 <= 2;
        return f3 inside {0, 1, 2, 4, 5};
    endfunction

    bit          if_pend, dm_pend, d_we;
    logic [31:0] if_a, dm_a, d_wd;
    logic [2:0]  d_f3;
    bit          e_ifv, e_ife, e_dmv, e_dme;
    logic [31:0] e_ifr, e_dmr;
    int          streak;

    initial begin
        bit gi, gd, ifl, dfl, rw;
        int p;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1]     = 32'h03502083;
        ref_mem[1] = 32'h03502083;

        rst_n         = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h4;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b1;
        bus.dm_funct3 = 3'b010;
        bus.dm_addr   = 32'h10;
        bus.dm_wdata  = 32'hdeadbeef;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", 32'(bus.if_gnt), 0);
        chk("rst_dm_gnt", 32'(bus.dm_gnt), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_mem_read", 32'(bus.mem_read), 0);
        chk("rst_if_valid", 32'(bus.if_valid), 0);
        chk("rst_dm_valid", 32'(bus.dm_valid), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);

        if_pend = 0;
        dm_pend = 0;
        streak  = 0;
        {e_ifv, e_ife, e_dmv, e_dme} = '0;
        e_ifr = 0;
        e_dmr = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            chk("mem4", mem[4], ref_mem[4]);
            chk("if_valid", 32'(bus.if_valid), 32'(e_ifv));
            chk("if_err", 32'(bus.if_err), 32'(e_ife));
            chk("if_rdata", bus.if_rdata, e_ifr);
            chk("dm_valid", 32'(bus.dm_valid), 32'(e_dmv));
            chk("dm_err", 32'(bus.dm_err), 32'(e_dme));
            chk("dm_rdata", bus.dm_rdata, e_dmr);

            p = (cyc >= 300 && cyc < 360) ? 100 : 55;
            if (!if_pend) begin
                if_pend = $urandom_range(0, 99) < p;
                if_a    = gen_addr();
            end
            if (!dm_pend) begin
                dm_pend = $urandom_range(0, 99) < p;
                dm_a    = gen_addr();
                d_we    = $urandom_range(0, 1);
                d_f3    = $urandom_range(0, 99) < 70 ? 3'b010
                          : 3'($urandom_range(0, 7));
                d_wd    = $urandom;
            end
            rw = (p == 100) || ($urandom_range(0, 39) != 0);
            rst_n         = rw;
            bus.if_req    = if_pend;
            bus.if_addr   = if_a;
            bus.dm_req    = dm_pend;
            bus.dm_we     = d_we;
            bus.dm_funct3 = d_f3;
            bus.dm_addr   = dm_a;
            bus.dm_wdata  = d_wd;
            #1;

            ifl = addr_bad(if_a);
            dfl = addr_bad(dm_a) || !f3_ok(d_we, d_f3);
            gd  = rw && dm_pend && !(if_pend && streak == MAXW);
            gi  = rw && if_pend && !gd;

            chk("if_gnt", 32'(bus.if_gnt), 32'(gi));
            chk("dm_gnt", 32'(bus.dm_gnt), 32'(gd));
            chk("if_stall", 32'(bus.if_stall), 32'(if_pend && !gi));
            chk("mem_read", 32'(bus.mem_read),
                32'((gd && !dfl && !d_we) || (gi && !ifl)));
            chk("mem_write", 32'(bus.mem_write), 32'(gd && !dfl && d_we));
            if (gd && !dfl) begin
                chk("mem_addr_dm", 32'(bus.mem_addr), dm_a / 4);
                chk("mem_f3_dm", 32'(bus.mem_funct3), 32'(d_f3));
                if (d_we)
                    chk("mem_wdata", bus.mem_wdata, d_wd);
            end else if (gi && !ifl) begin
                chk("mem_addr_if", 32'(bus.mem_addr), if_a / 4);
                chk("mem_f3_if", 32'(bus.mem_funct3), 2);
            end else if (!gi && !gd) begin
                chk("mem_addr_idle", 32'(bus.mem_addr), 0);
            end

            e_ifv = gi;
            e_dmv = gd;
            e_ife = gi && ifl;
            e_dme = gd && dfl;
            if (!rw) begin
                e_ifr = 0;
                e_dmr = 0;
            end else if (gd) begin
                if (dfl || d_we)
                    e_dmr = 0;
                else
                    e_dmr = rd(ref_mem[dm_a / 4], d_f3);
                if (!dfl && d_we)
                    ref_mem[dm_a / 4] = wr(ref_mem[dm_a / 4], d_wd, d_f3);
            end else if (gi) begin
                e_ifr = ifl ? 0 : ref_mem[if_a / 4];
            end

            if (!rw || !if_pend || gi)
                streak = 0;
            else if (streak < MAXW)
                streak++;
            if (gi)
                if_pend = 0;
            if (gd)
                dm_pend = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/umem_port_arbiter.md
Name: umem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory (64 x 32-bit words, word-indexed, sub-word select via funct3) between the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants at most one requester per cycle and drives the memory-side control/address/data.
- Registers the read data back to the winner and raises a fetch stall for the hazard unit.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- MAX_FETCH_WAIT, 4, consecutive cycles fetch may be denied before it is forced a grant (1..15)
- ADDR_W, 6, memory word-index width (memory depth 2^ADDR_W)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_stall  out  1  if_req & ~if_gnt
- if_valid  out  1  fetch data valid (registered, cycle after grant)
- if_err  out  1  fetch address fault, with if_valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_funct3  in  3  RV32I load/store funct3
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data granted this cycle (combinational)
- dm_valid  out  1  data access complete (registered)
- dm_err  out  1  data access fault, with dm_valid
- dm_rdata  out  32  load data
- mem_addr  out  ADDR_W  word index to memory
- mem_read  out  1  memory MemRead
- mem_write  out  1  memory MemWrite
- mem_funct3  out  3  memory funct3
- mem_wdata  out  32  memory data_in
- mem_rdata  in  32  memory data_out (combinational)

Behaviour:
- Reset (rst_n=0 at posedge): wait_cnt=0, owner=NONE; if_valid, dm_valid, if_err, dm_err = 0; if_rdata, dm_rdata = 0.
- While rst_n=0, gnts, mem_read and mem_write are forced 0 combinationally, so no store lands during reset.
- Arbitration (combinational, per cycle):
  - Only dm_req: data wins.
  - Only if_req: fetch wins.
  - Both, wait_cnt < MAX_FETCH_WAIT: data wins.
  - Both, wait_cnt == MAX_FETCH_WAIT: fetch wins.
- wait_cnt:
  - +1 when if_req and not if_gnt, saturating at MAX_FETCH_WAIT.
  - Cleared on if_gnt or when if_req=0.
- Address check:
  - word index = addr[ADDR_W+1:2].
  - Fault if addr[31:ADDR_W+2] != 0 or addr[1:0] != 0. Memory serves sub-word from lane 0 only, so nonzero offsets are faults.
  - Data also faults on illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- Granted data, no fault:
  - mem_addr = index, mem_funct3 = dm_funct3.
  - mem_read = ~dm_we, mem_write = dm_we, mem_wdata = dm_wdata.
  - Store commits at the end of the grant cycle.
- Granted fetch, no fault: mem_read=1, mem_write=0, mem_funct3=010.
- Faulted grant: the request is consumed (gnt=1) but mem_read=mem_write=0 (no memory access).
- No grant: mem_read=mem_write=0; mem_addr, mem_funct3, mem_wdata = 0.
- Response (registered; latency 1):
  - Cycle after a grant: owner's valid=1; rdata = mem_rdata sampled at the grant edge (0 for stores and faults); err = fault.
  - Valid is a one-cycle pulse; rdata holds until the next valid for that port.
- Requesters hold req/addr/data until gnt; the arbiter never drops a held request.
- Back-to-back grants every cycle are legal; one request per requester per grant.
- Reset asserted in the cycle after a grant: the pending valid is suppressed (cleared).

Test Plan:
- Fetch only, if_addr=0x4 with mem[1]=0x03502083 -> if_gnt same cycle; next cycle if_valid=1, if_rdata=0x03502083, if_err=0.
- dm store SW, addr=0x0C, wdata=34, then load LW addr=0x0C -> mem_write=1 with mem_addr=3 on store; load dm_rdata=34 one cycle after its grant.
- dm_req and if_req both held high continuously, MAX_FETCH_WAIT=4 -> dm granted 4 cycles, fetch granted on the 5th; the pattern repeats; if_stall high exactly on the denied cycles.
- LH at addr=0xD6 (offset 2) and SB with funct3=011 -> dm_gnt=1, mem_write=0, next cycle dm_valid=1, dm_err=1, dm_rdata=0; memory unchanged.
- Fetch at if_addr=0x100 (out of range) -> if_gnt=1, mem_read=0, next cycle if_valid=1, if_err=1.
- rst_n=0 in the same cycle as a granted SW to addr=0x10 -> mem_write=0, mem[4] unchanged; after reset all valids 0 and wait_cnt=0.
